// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// Contents:
//   MEM_* access codes for the data port (3-bit function code)
//   ARB_TAG_* values and arb_tag_e, the tag of the access currently in flight
//   fn_is_store(): true for SB/SH/SW
package mem_port_arbiter_pkg;

  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LH  = 3'd1;
  localparam logic [2:0] MEM_LW  = 3'd2;
  localparam logic [2:0] MEM_SB  = 3'd3;
  localparam logic [2:0] MEM_LBU = 3'd4;
  localparam logic [2:0] MEM_LHU = 3'd5;
  localparam logic [2:0] MEM_SH  = 3'd6;
  localparam logic [2:0] MEM_SW  = 3'd7;

  localparam logic [1:0] ARB_TAG_IDLE  = 2'd0;
  localparam logic [1:0] ARB_TAG_FETCH = 2'd1;
  localparam logic [1:0] ARB_TAG_DATA  = 2'd2;

  typedef enum logic [1:0] {
    TagIdle  = ARB_TAG_IDLE,
    TagFetch = ARB_TAG_FETCH,
    TagData  = ARB_TAG_DATA
  } arb_tag_e;

  function automatic logic fn_is_store(input logic [2:0] fn);
    return (fn == MEM_SB) || (fn == MEM_SH) || (fn == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for a 32-bit word memory (purely combinational).
// Request side (issue cycle):
//   i_req_fn, i_req_addr_lo, i_wdata -> o_be (0 for loads/misaligned), o_wdata_lane, o_misalign
// Response side (cycle after issue, from the registered fn/addr):
//   i_rsp_fn, i_rsp_addr_lo, i_rdata -> o_rdata_ext (sign/zero-extended load, 0 for stores)
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]  i_req_fn,
  input  logic [1:0]  i_req_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_rsp_fn,
  input  logic [1:0]  i_rsp_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_lane,
  output logic [31:0] o_rdata_ext,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be         = 4'b0000;
    o_wdata_lane = 32'h0;
    o_misalign   = 1'b0;
    case (i_req_fn)
      MEM_SB: begin
        o_be         = 4'b0001 << i_req_addr_lo;
        o_wdata_lane = {4{i_wdata[7:0]}};
      end
      MEM_SH: begin
        o_be         = 4'b0011 << {i_req_addr_lo[1], 1'b0};
        o_wdata_lane = {2{i_wdata[15:0]}};
        o_misalign   = i_req_addr_lo[0];
      end
      MEM_SW: begin
        o_be         = 4'b1111;
        o_wdata_lane = i_wdata;
        o_misalign   = |i_req_addr_lo;
      end
      MEM_LH, MEM_LHU: o_misalign = i_req_addr_lo[0];
      MEM_LW:          o_misalign = |i_req_addr_lo;
      default: ;
    endcase
    // A misaligned access still occupies the port but must never write.
    if (o_misalign) o_be = 4'b0000;
  end

  always_comb begin
    case (i_rsp_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_rsp_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_rsp_fn)
      MEM_LBU:                o_rdata_ext = {24'h0, w_byte};
      MEM_LH:                 o_rdata_ext = {{16{w_half[15]}}, w_half};
      MEM_LHU:                o_rdata_ext = {16'h0, w_half};
      MEM_LW:                 o_rdata_ext = i_rdata;
      MEM_SB, MEM_SH, MEM_SW: o_rdata_ext = 32'h0;
      // Anything unrecognised behaves as LB.
      default:                o_rdata_ext = {{24{w_byte[7]}}, w_byte};
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous word memory between the fetch port (i_if_*)
// and the data port (i_d_*). One grant per cycle, read data one cycle after the grant.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_if_req/i_if_addr/i_if_kill   fetch request (held until o_if_gnt), pc, redirect kill
//   o_if_gnt/o_if_rvalid/o_if_rdata fetch grant and instruction response
//   i_d_req/i_d_fn/i_d_addr/i_d_wdata data request (held until o_d_gnt)
//   o_d_gnt/o_d_rvalid/o_d_rdata/o_d_err data grant, response and misalign error
//   o_m_en/o_m_be/o_m_addr/o_m_wdata memory macro command; i_m_rdata macro read data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_LEN    = 32,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [DATA_LEN-1:0] i_if_addr,
  input  logic                i_if_kill,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_LEN-1:0] o_if_rdata,
  input  logic                i_d_req,
  input  logic [2:0]          i_d_fn,
  input  logic [DATA_LEN-1:0] i_d_addr,
  input  logic [DATA_LEN-1:0] i_d_wdata,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [DATA_LEN-1:0] o_d_rdata,
  output logic                o_d_err,
  output logic                o_m_en,
  output logic [3:0]          o_m_be,
  output logic [DATA_LEN-1:0] o_m_addr,
  output logic [DATA_LEN-1:0] o_m_wdata,
  input  logic [DATA_LEN-1:0] i_m_rdata
);

  localparam logic [3:0] MaxBurst = MAX_D_BURST[3:0];

  logic [3:0]          r_d_cnt;
  arb_tag_e            r_tag;
  logic [2:0]          r_fn;
  logic [1:0]          r_addr_lo;
  logic                r_err;

  logic                w_if_ok;
  logic                w_force_if;
  logic                w_if_gnt;
  logic                w_d_gnt;
  logic [3:0]          w_d_cnt_next;
  logic [3:0]          w_be;
  logic [DATA_LEN-1:0] w_wdata_lane;
  logic [DATA_LEN-1:0] w_rdata_ext;
  logic                w_misalign;
  logic                w_unused_if_addr_lo;

  // Fetches are word aligned; the low pc bits carry no information here.
  assign w_unused_if_addr_lo = ^i_if_addr[1:0];

  mem_lane_align u_lane (
    .i_req_fn      (i_d_fn),
    .i_req_addr_lo (i_d_addr[1:0]),
    .i_wdata       (i_d_wdata),
    .i_rsp_fn      (r_fn),
    .i_rsp_addr_lo (r_addr_lo),
    .i_rdata       (i_m_rdata),
    .o_be          (w_be),
    .o_wdata_lane  (w_wdata_lane),
    .o_rdata_ext   (w_rdata_ext),
    .o_misalign    (w_misalign)
  );

  // Data wins by default; a fetch that has waited out MAX_D_BURST data grants takes the
  // port. A killed fetch is not eligible, so data may still go in that cycle.
  always_comb begin
    w_if_ok    = i_rst_n & i_if_req & ~i_if_kill;
    w_force_if = w_if_ok & (r_d_cnt == MaxBurst);
    w_d_gnt    = i_rst_n & i_d_req & ~w_force_if;
    w_if_gnt   = w_if_ok & ~w_d_gnt;
  end

  always_comb begin
    w_d_cnt_next = r_d_cnt;
    if (w_if_gnt || !i_if_req) begin
      w_d_cnt_next = 4'd0;
    end else if (w_d_gnt && (r_d_cnt != MaxBurst)) begin
      w_d_cnt_next = r_d_cnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d_cnt   <= 4'd0;
      r_tag     <= TagIdle;
      r_fn      <= MEM_LB;
      r_addr_lo <= 2'd0;
      r_err     <= 1'b0;
    end else begin
      r_d_cnt <= w_d_cnt_next;
      if (w_d_gnt) begin
        r_tag     <= TagData;
        r_fn      <= i_d_fn;
        r_addr_lo <= i_d_addr[1:0];
        r_err     <= w_misalign;
      end else if (w_if_gnt) begin
        r_tag <= TagFetch;
      end else begin
        r_tag <= TagIdle;
      end
    end
  end

  always_comb begin
    o_if_gnt  = w_if_gnt;
    o_d_gnt   = w_d_gnt;
    o_m_en    = w_if_gnt | w_d_gnt;
    o_m_be    = 4'b0000;
    o_m_addr  = '0;
    o_m_wdata = '0;
    if (w_d_gnt) begin
      o_m_be    = w_be;
      o_m_addr  = {i_d_addr[DATA_LEN-1:2], 2'b00};
      o_m_wdata = w_wdata_lane;
    end else if (w_if_gnt) begin
      o_m_addr = {i_if_addr[DATA_LEN-1:2], 2'b00};
    end
  end

  // Responses: a kill arriving in the response cycle drops the fetched word.
  always_comb begin
    o_if_rvalid = (r_tag == TagFetch) & ~i_if_kill;
    o_if_rdata  = o_if_rvalid ? i_m_rdata : '0;
    o_d_rvalid  = (r_tag == TagData);
    o_d_err     = o_d_rvalid & r_err;
    o_d_rdata   = (o_d_rvalid && !r_err) ? w_rdata_ext : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MaxB = 4;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, if_kill = 1'b0, d_req = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [2:0]  d_fn = MEM_LB;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, m_en;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;

  mem_port_arbiter #(.DATA_LEN(32), .MAX_D_BURST(MaxB)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_kill(if_kill),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_fn(d_fn), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_m_en(m_en), .o_m_be(m_be), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
    .i_m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro: 1 KiB, read data one cycle after m_en, byte-enabled writes.
  logic [31:0] mmem [0:255] = '{default: 32'h0};
  always @(posedge clk) begin
    if (m_en) begin
      m_rdata <= mmem[m_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mmem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end
  end

  // Reference: byte-addressed golden memory and response queues.
  logic [7:0] gmem [0:1023] = '{default: 8'h0};
  rsp_t fq[$], dq[$];
  int   cyc = 0, burst = 0;
  int   n_tests = 0, n_fail = 0;
  logic s_if_gnt, s_d_gnt, s_if_rvalid, s_d_rvalid, s_d_err;
  logic [31:0] s_if_rdata, s_d_rdata, s_m_wdata;
  logic [3:0]  s_m_be;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    int b = int'(a & 32'h3FC);
    return {gmem[b+3], gmem[b+2], gmem[b+1], gmem[b]};
  endfunction

  function automatic logic [31:0] gold_load(input logic [2:0] fn, input logic [31:0] a);
    int x = int'(a & 32'h3FF);
    logic [7:0]  by = gmem[x];
    logic [15:0] hw = {gmem[(x+1) & 1023], gmem[x]};
    case (fn)
      MEM_LBU: return {24'h0, by};
      MEM_LH:  return {{16{hw[15]}}, hw};
      MEM_LHU: return {16'h0, hw};
      MEM_LW:  return gold_word(a);
      default: return {{24{by[7]}}, by};
    endcase
  endfunction

  task automatic step(input logic rst, input logic ifr, input logic [31:0] ifa, input logic kill,
                      input logic dr, input logic [2:0] fn, input logic [31:0] da,
                      input logic [31:0] wd);
    logic fetch_ok, exp_ig, exp_dg, mis, is_st;
    int sz, a;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    rsp_t e;
    @(negedge clk);
    cyc++;
    rst_n = rst; if_req = ifr; if_addr = ifa; if_kill = kill;
    d_req = dr; d_fn = fn; d_addr = da; d_wdata = wd;
    if (!rst) begin
      fq.delete(); dq.delete(); burst = 0;
    end
    #1;
    s_if_gnt = if_gnt; s_d_gnt = d_gnt; s_if_rvalid = if_rvalid; s_if_rdata = if_rdata;
    s_d_rvalid = d_rvalid; s_d_rdata = d_rdata; s_d_err = d_err;
    s_m_be = m_be; s_m_wdata = m_wdata;
    exp_ig = 1'b0; exp_dg = 1'b0;
    if (rst) begin
      fetch_ok = ifr && !kill;
      if (dr && !(fetch_ok && burst == MaxB)) exp_dg = 1'b1;
      else if (fetch_ok) exp_ig = 1'b1;
    end
    chk("if_gnt", {31'h0, if_gnt}, {31'h0, exp_ig});
    chk("d_gnt", {31'h0, d_gnt}, {31'h0, exp_dg});
    chk("m_en", {31'h0, m_en}, {31'h0, exp_ig | exp_dg});
    if (!rst) begin
      chk("rst_m_be", {28'h0, m_be}, 32'h0);
      chk("rst_m_addr", m_addr, 32'h0);
      chk("rst_m_wdata", m_wdata, 32'h0);
    end
    if (exp_ig) begin
      chk("if_m_addr", m_addr, ifa & ~32'h3);
      chk("if_m_be", {28'h0, m_be}, 32'h0);
      e.due = cyc + 1; e.data = gold_word(ifa); e.err = 1'b0;
      fq.push_back(e);
    end
    if (exp_dg) begin
      sz = (fn == MEM_LW || fn == MEM_SW) ? 4 :
           (fn == MEM_LH || fn == MEM_LHU || fn == MEM_SH) ? 2 : 1;
      mis = (int'(da[1:0]) % sz) != 0;
      is_st = (fn == MEM_SB || fn == MEM_SH || fn == MEM_SW);
      exp_be = (is_st && !mis) ? 4'(((1 << sz) - 1) << da[1:0]) : 4'h0;
      chk("d_m_addr", m_addr, da & ~32'h3);
      chk("d_m_be", {28'h0, m_be}, {28'h0, exp_be});
      if (is_st && !mis) begin
        exp_wd = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
        chk("d_m_wdata", m_wdata, exp_wd);
        a = int'(da & 32'h3FF);
        for (int k = 0; k < sz; k++) gmem[a+k] = wd[8*k +: 8];
      end
      e.due = cyc + 1; e.err = mis;
      e.data = (is_st || mis) ? 32'h0 : gold_load(fn, da);
      dq.push_back(e);
    end
    if (!rst || exp_ig || !ifr) burst = 0;
    else if (exp_dg && burst < MaxB) burst++;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, MEM_LB, 32'h0, 32'h0);
  endtask

  // Monitor: compares every presented response against the queued expectation.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (fq.size() > 0 && fq[0].due == cyc) begin
        e = fq.pop_front();
        if (if_kill) chk("if_rvalid_killed", {31'h0, if_rvalid}, 32'h0);
        else begin
          chk("if_rvalid", {31'h0, if_rvalid}, 32'h1);
          chk("if_rdata", if_rdata, e.data);
        end
      end else chk("if_rvalid_spurious", {31'h0, if_rvalid}, 32'h0);
      if (dq.size() > 0 && dq[0].due == cyc) begin
        e = dq.pop_front();
        chk("d_rvalid", {31'h0, d_rvalid}, 32'h1);
        chk("d_rdata", d_rdata, e.data);
        chk("d_err", {31'h0, d_err}, {31'h0, e.err});
      end else chk("d_rvalid_spurious", {31'h0, d_rvalid}, 32'h0);
    end
  end

  initial begin
    logic [7:0] dpat, ipat;
    logic f_pend, d_pend, kill;
    logic [31:0] f_addr, dd_addr, dd_wd;
    logic [2:0] dd_fn;

    // Reset with both requesters active: nothing may be granted or driven.
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, MEM_LW, 32'h300, 32'h0);
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, MEM_LW, 32'h300, 32'h0);
    idle();

    // Fetch of a known instruction word.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, MEM_SW, 32'h100, 32'h13);
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, MEM_LB, 32'h0, 32'h0);
    chk("t1_if_gnt", {31'h0, s_if_gnt}, 32'h1);
    idle();
    chk("t1_if_rvalid", {31'h0, s_if_rvalid}, 32'h1);
    chk("t1_if_rdata", s_if_rdata, 32'h13);

    // Both requesting for 8 cycles: D,D,D,D,I,D,D,D.
    dpat = '0; ipat = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 32'h104, 1'b0, 1'b1, MEM_LW, 32'h300, 32'h0);
      dpat = {dpat[6:0], s_d_gnt};
      ipat = {ipat[6:0], s_if_gnt};
    end
    chk("t2_d_pattern", {24'h0, dpat}, 32'hF7);
    chk("t2_if_pattern", {24'h0, ipat}, 32'h08);
    idle();

    // Byte store/loads.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, MEM_SB, 32'h203, 32'hAB);
    chk("t3_sb_be", {28'h0, s_m_be}, 32'h8);
    chk("t3_sb_wdata", s_m_wdata, 32'hABABABAB);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, MEM_LB, 32'h203, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, MEM_LBU, 32'h203, 32'h0);
    chk("t3_lb", s_d_rdata, 32'hFFFFFFAB);
    idle();
    chk("t3_lbu", s_d_rdata, 32'h000000AB);

    // Half store/loads.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, MEM_SH, 32'h202, 32'h8001);
    chk("t4_sh_be", {28'h0, s_m_be}, 32'hC);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, MEM_LH, 32'h202, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, MEM_LHU, 32'h202, 32'h0);
    chk("t4_lh", s_d_rdata, 32'hFFFF8001);
    idle();
    chk("t4_lhu", s_d_rdata, 32'h00008001);

    // Misaligned word accesses.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, MEM_LW, 32'h201, 32'h0);
    chk("t5_lw_be", {28'h0, s_m_be}, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, MEM_SW, 32'h206, 32'hDEADBEEF);
    chk("t5_lw_err", {29'h0, s_d_rvalid, s_d_err, |s_d_rdata}, 32'h6);
    chk("t5_sw_be", {28'h0, s_m_be}, 32'h0);
    idle();
    chk("t5_sw_err", {30'h0, s_d_rvalid, s_d_err}, 32'h3);

    // Kill in the response cycle drops the fetch and blocks a new fetch grant.
    step(1'b1, 1'b1, 32'h108, 1'b0, 1'b0, MEM_LB, 32'h0, 32'h0);
    chk("t6_if_gnt", {31'h0, s_if_gnt}, 32'h1);
    step(1'b1, 1'b1, 32'h10C, 1'b1, 1'b0, MEM_LB, 32'h0, 32'h0);
    chk("t6_kill", {30'h0, s_if_gnt, s_if_rvalid}, 32'h0);
    step(1'b1, 1'b1, 32'h10C, 1'b0, 1'b0, MEM_LB, 32'h0, 32'h0);
    chk("t6_regrant", {31'h0, s_if_gnt}, 32'h1);
    idle();

    // Reset in the response cycle of a load discards the response.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, MEM_LW, 32'h300, 32'h0);
    chk("t6_ld_gnt", {31'h0, s_d_gnt}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, MEM_LB, 32'h0, 32'h0);
    chk("t6_rst_rvalid", {31'h0, s_d_rvalid}, 32'h0);
    idle();
    chk("t6_post_rvalid", {31'h0, s_d_rvalid}, 32'h0);

    // Randomized traffic with requesters that hold until granted.
    f_pend = 1'b0; d_pend = 1'b0;
    f_addr = '0; dd_addr = '0; dd_wd = '0; dd_fn = MEM_LB;
    for (int i = 0; i < 2500; i++) begin
      if (!f_pend && ($urandom_range(3) != 0)) begin
        f_pend = 1'b1; f_addr = $urandom_range(255) * 4;
      end
      if (!d_pend && ($urandom_range(3) != 0)) begin
        d_pend = 1'b1; dd_fn = 3'($urandom_range(7));
        dd_addr = $urandom_range(1023); dd_wd = $urandom;
        if ($urandom_range(3) != 0) dd_addr = dd_addr & ~32'h3;
      end
      kill = ($urandom_range(7) == 0);
      step(($urandom_range(499) != 0), f_pend, f_addr, kill, d_pend, dd_fn, dd_addr, dd_wd);
      if (!rst_n) begin
        f_pend = 1'b0; d_pend = 1'b0;
      end
      if (s_if_gnt) f_pend = 1'b0;
      if (s_d_gnt) d_pend = 1'b0;
    end
    idle();
    idle();
    chk("fq_drained", fq.size(), 32'h0);
    chk("dq_drained", dq.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
